// File: rtl/seq_alu_package.sv
// Shared constants and entry layout for the ALU result FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package seq_alu_package;

    localparam int RES_W_DEF = 8;
    localparam int OPC_W_DEF = 3;
    localparam int DEPTH_DEF = 8;

    // Drop counter is 8 bits wide and sticks at its maximum
    localparam logic [7:0] DROP_SAT = 8'd255;

    // One stored result: opcode tag in the upper bits, ALU result below
    typedef struct packed {
        logic [OPC_W_DEF-1:0] opcode;
        logic [RES_W_DEF-1:0] result;
    } alu_entry_t;

endpackage

// File: rtl/seq_alu_res_mem.sv
// Entry storage: DEPTH words, one synchronous write port, one asynchronous read port.
// Latency: write visible on read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when to write. No reset on contents.
module seq_alu_res_mem #(
    parameter int ENTRY_W = 11,
    parameter int DEPTH   = 8,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_dat,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_dat
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Capture the incoming entry at the write pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/seq_alu_result_fifo.sv
// Buffers {opcode, result} pairs from the ALU in write order for a downstream consumer.
// Latency: an entry written into an empty FIFO is presented one cycle after its write edge.
// Backpressure: valid/ready on the output; when full, ALU results are dropped and counted unless a read frees a slot.
module seq_alu_result_fifo
    import seq_alu_package::*;
#(
    parameter int RES_W = RES_W_DEF,
    parameter int OPC_W = OPC_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     alu_valid,
    input  logic [RES_W-1:0]         alu_out,
    input  logic [OPC_W-1:0]         alu_opcode,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [RES_W-1:0]         out_data,
    output logic [OPC_W-1:0]         out_opcode,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_W   = AW + 1;
    localparam int ENTRY_W = OPC_W + RES_W;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [ENTRY_W-1:0] head_entry;
    logic               rd_en;
    logic               wr_en;
    logic               drop_evt;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    // A read frees the head slot on the same edge, so a full FIFO can still take a write
    assign rd_en    = out_valid && out_ready;
    assign wr_en    = alu_valid && (!full || rd_en);
    assign drop_evt = alu_valid && full && !rd_en && !flush;

    seq_alu_res_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && !flush),
        .wr_addr (wr_ptr),
        .wr_dat  ({alu_opcode, alu_out}),
        .rd_addr (rd_ptr),
        .rd_dat  (head_entry)
    );

    assign out_opcode = head_entry[ENTRY_W-1:RES_W];
    assign out_data   = head_entry[RES_W-1:0];

    // Pointer and occupancy tracking; flush empties the FIFO and discards same-cycle traffic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_W'(1);
            end else if (rd_en && !wr_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Saturating count of results lost to a full FIFO; flush leaves it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_evt && (drop_cnt != DROP_SAT)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_seq_alu_result_fifo.sv
module tb_seq_alu_result_fifo;
    import seq_alu_package::*;

    localparam int RES_W = 8;
    localparam int OPC_W = 3;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             alu_valid;
    logic [RES_W-1:0] alu_out;
    logic [OPC_W-1:0] alu_opcode;
    logic             out_ready;
    logic             out_valid;
    logic [RES_W-1:0] out_data;
    logic [OPC_W-1:0] out_opcode;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic [7:0]       drop_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: ordered list of stored entries plus a drop counter
    alu_entry_t q[$];
    int         mdrop = 0;

    seq_alu_result_fifo #(
        .RES_W (RES_W),
        .OPC_W (OPC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .alu_valid  (alu_valid),
        .alu_out    (alu_out),
        .alu_opcode (alu_opcode),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_opcode (out_opcode),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one edge's worth of traffic to the model, using pre-edge model state
    task automatic model_step(input logic v, input logic [7:0] d, input logic [2:0] op,
                              input logic rdy, input logic fl);
        bit rd;
        bit fullm;
        bit wr;
        alu_entry_t e;
        rd    = (q.size() != 0) && rdy;
        fullm = (q.size() == DEPTH);
        wr    = v && (!fullm || rd);
        if (fl) begin
            q.delete();
        end else begin
            if (rd) void'(q.pop_front());
            if (wr) begin
                e.opcode = op;
                e.result = d;
                q.push_back(e);
            end
            if (v && fullm && !rd && mdrop != 255) mdrop++;
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("count",     32'(count),     32'(q.size()));
        chk("full",      32'(full),      32'(q.size() == DEPTH));
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("drop_cnt",  32'(drop_cnt),  32'(mdrop));
        if (q.size() != 0) begin
            chk("out_data",   32'(out_data),   32'(q[0].result));
            chk("out_opcode", 32'(out_opcode), 32'(q[0].opcode));
        end
    endtask

    // Inputs are driven just after a falling edge; outputs are checked on the next falling edge
    task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] op,
                         input logic rdy, input logic fl);
        alu_valid  = v;
        alu_out    = d;
        alu_opcode = op;
        out_ready  = rdy;
        flush      = fl;
        @(posedge clk);
        model_step(v, d, op, rdy, fl);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alu_valid = 1'b0; alu_out = '0;
        alu_opcode = '0; out_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_empty", 32'(empty),     32'd1);
        chk("rst_full",  32'(full),      32'd0);
        chk("rst_drop",  32'(drop_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single write becomes visible one cycle later
        cycle(1'b1, 8'h3C, 3'd2, 1'b0, 1'b0);
        chk("t1_valid",  32'(out_valid),  32'd1);
        chk("t1_data",   32'(out_data),   32'h3C);
        chk("t1_opcode", 32'(out_opcode), 32'd2);
        chk("t1_count",  32'(count),      32'd1);
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk("t1_hold",   32'(out_data),   32'h3C);
        cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        chk("t1_drained", 32'(empty), 32'd1);

        // Fill, overflow by three, then drain in order
        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 3'(i), 1'b0, 1'b0);
        chk("t2_full",  32'(full),  32'd1);
        chk("t2_count", 32'(count), 32'd8);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 3'd7, 1'b0, 1'b0);
        chk("t2_drop", 32'(drop_cnt), 32'd3);
        for (int i = 1; i <= 8; i++) begin
            chk("t2_order", 32'(out_data), 32'(i));
            cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // Full FIFO with simultaneous read and write keeps occupancy and order
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i), 3'd5, 1'b1, 1'b0);
        chk("t3_count", 32'(count),    32'd8);
        chk("t3_drop",  32'(drop_cnt), 32'd3);
        for (int k = 0; k < 8; k++) begin
            chk("t3_order", 32'(out_data), (k < 4) ? 32'(8'h14 + k) : 32'(8'h20 + k - 4));
            cycle(1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
        end

        // Flush with a concurrent write empties the FIFO and leaves drops alone
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'h40 + 8'(i), 3'd3, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 3'd4, 1'b1, 1'b1);
        chk("t4_count", 32'(count),    32'd0);
        chk("t4_empty", 32'(empty),    32'd1);
        chk("t4_drop",  32'(drop_cnt), 32'd3);

        // Drop counter saturates
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'h50 + 8'(i), 3'd6, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'hAA, 3'd0, 1'b0, 1'b0);
        chk("t5_sat", 32'(drop_cnt), 32'd255);
        cycle(1'b1, 8'hAB, 3'd0, 1'b0, 1'b0);
        chk("t5_hold", 32'(drop_cnt), 32'd255);
        chk("t5_head", 32'(out_data), 32'h50);

        // Asynchronous reset mid-cycle with five entries stored
        cycle(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 3'd2, 1'b0, 1'b0);
        chk("t6_pre", 32'(count), 32'd5);
        alu_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        q.delete();
        mdrop = 0;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_count", 32'(count),     32'd0);
        chk("t6_empty", 32'(empty),     32'd1);
        chk("t6_drop",  32'(drop_cnt),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 8'h77, 3'd1, 1'b0, 1'b0);
        chk("t6_first", 32'(out_data), 32'h77);

        // Randomized traffic with alternating backpressure phases and rare flushes
        for (int i = 0; i < 3000; i++) begin
            logic v, rdy, fl;
            v   = ($urandom_range(0, 3) != 0);
            rdy = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 99) == 0);
            cycle(v, 8'($urandom), 3'($urandom), rdy, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
